e203_ifu_flush_rsp: RTL and testbench
=====================================

Name: e203_ifu_flush_rsp

Overview:
- IFU-side responder for the EXU commit flush/halt interface. Receives `pipe_flush_req` with adder operands and computes the flush PC.
- Acknowledges the flush and redirects the sequential fetch stream to the flush PC.
- Marks responses of fetches issued before the flush as stale so the IFU drops them.
- Also serves the WFI halt request/ack handshake by draining outstanding fetches before acknowledging.

Parameters:
- PC_SIZE, 32, width of PC and flush operands.
- MAX_OUTS, 2, maximum accepted-but-unresponded fetch requests (1..7).
- RESET_PC, 32'h8000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_flush_req  in  1  flush request from commit; held until acked.
- pipe_flush_add_op1  in  PC_SIZE  flush PC operand 1.
- pipe_flush_add_op2  in  PC_SIZE  flush PC operand 2.
- pipe_flush_ack  out  1  flush accepted this cycle (combinational).
- halt_req  in  1  WFI halt request from commit; level.
- halt_ack  out  1  IFU halted and drained (registered).
- ifu_req_valid  out  1  fetch request valid (registered).
- ifu_req_ready  in  1  memory accepts request.
- ifu_req_pc  out  PC_SIZE  fetch address.
- ifu_rsp_valid  in  1  fetch response returns (in order; always accepted).
- ifu_rsp_keep  out  1  response belongs to the current stream.
- ifu_rsp_discard  out  1  response is stale; IFU must drop it.

Behaviour:
- Reset values:
  - pc_r=RESET_PC, ifu_req_valid=0, outs_cnt=0, stale_cnt=0, state=RUN, halt_ack=0.
  - pipe_flush_ack, ifu_rsp_keep and ifu_rsp_discard follow their equations, so they are 0 when their inputs are idle.
  - Reset mid-operation discards all counts and in-flight knowledge.
- ifu_req_pc = pc_r.
- Request handshake: req_hs = ifu_req_valid & ifu_req_ready.
  - Once ifu_req_valid is raised it holds until req_hs; address is stable while it holds.
  - On req_hs, pc_r <= pc_r+4 (mod 2^PC_SIZE) unless a flush handshake occurs the same cycle.
- Counters:
  - outs_nxt = outs_cnt + req_hs - ifu_rsp_valid. If ifu_rsp_valid arrives while outs_cnt=0 it is a protocol error; the decrement saturates at 0.
  - ifu_rsp_discard = ifu_rsp_valid & (stale_cnt!=0); ifu_rsp_keep = ifu_rsp_valid & (stale_cnt==0).
  - stale_cnt decrements on each discarded response.
- Raising valid: ifu_req_valid <= 1 next cycle when all of the following hold:
  - state=RUN, halt_req=0, pipe_flush_req=0;
  - outs_nxt < MAX_OUTS;
  - (ifu_req_valid=0 or req_hs).
  - Otherwise it clears after req_hs, or holds if still pending.
- Flush:
  - pipe_flush_ack = pipe_flush_req & ~halt_req & ~(ifu_req_valid & ~ifu_req_ready). A pending unaccepted request blocks the ack; valid never drops without a handshake.
  - Flush handshake cycle (req & ack):
    - pc_r <= pipe_flush_add_op1 + pipe_flush_add_op2, truncated to PC_SIZE (wraps).
    - stale_cnt <= outs_nxt, so every in-flight request, including one accepted this cycle, becomes stale.
    - state <= RUN.
  - The first redirected request is valid the cycle after the handshake, at the flush PC.
  - A flush with halt_req=1 is not acked (commit guarantees one-hot; the block stays safe anyway).
- Halt state machine:
  - RUN -> HALTING when halt_req=1.
  - HALTING -> HALTED when outs_cnt=0 and ifu_req_valid=0.
  - HALTED: halt_ack=1 (registered, asserted on entry).
  - HALTING/HALTED -> RUN when halt_req=0; halt_ack clears the same edge.
  - No new requests are raised in HALTING/HALTED; a pending request still completes.

Test Plan:
- Reset, ready=1, responses 1 cycle after accept -> ifu_req_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; all responses ifu_rsp_keep=1.
- ready=0, two accepted in-flight (outs=2, MAX_OUTS=2) -> ifu_req_valid stays 0 until a response arrives.
- Flush while valid & ~ready, op1=0x8000_0100, op2=0x20 -> ack=0 until ready=1. Handshake accepts the old request and acks in the same cycle. Next ifu_req_pc=0x8000_0120.
- Flush with outs_cnt=2 and no pending request -> ack same cycle. Next two responses have discard=1, the third has keep=1.
- Flush with op1=0xFFFF_FFF0, op2=0x20 -> ifu_req_pc=0x0000_0010 (wrap).
- Halt with outs=1 -> halt_ack rises 1 cycle after the last response. Deassert halt_req -> halt_ack=0 and fetch resumes at the next sequential PC.

Source files
------------

// File: rtl/e203_ifu_flush_rsp.sv
// e203_ifu_flush_rsp
//
// IFU-side responder for the commit flush/halt interface. It owns the
// sequential fetch PC, issues fetch requests to memory, accepts flush
// redirects from commit, marks responses of pre-flush fetches as stale,
// and serves the WFI halt handshake by draining outstanding fetches
// before acknowledging.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   pipe_flush_req        flush request from commit, held until acked
//   pipe_flush_add_op1/2  operands whose sum is the flush PC
//   pipe_flush_ack        flush accepted this cycle (combinational)
//   halt_req              WFI halt request (level)
//   halt_ack              fetch halted and drained (registered)
//   ifu_req_valid/ready   fetch request handshake to memory
//   ifu_req_pc            fetch address
//   ifu_rsp_valid         in-order fetch response, always accepted
//   ifu_rsp_keep          response belongs to the current fetch stream
//   ifu_rsp_discard       response predates a flush and must be dropped

module e203_ifu_flush_rsp #(
  parameter int                 PC_SIZE  = 32,
  parameter int                 MAX_OUTS = 2,
  parameter logic [PC_SIZE-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipe_flush_req,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
  output logic               pipe_flush_ack,
  input  logic               halt_req,
  output logic               halt_ack,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_SIZE-1:0] ifu_req_pc,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_keep,
  output logic               ifu_rsp_discard
);

  // Counter wide enough to hold MAX_OUTS itself.
  localparam int CNT_W = $clog2(MAX_OUTS + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTING,
    ST_HALTED
  } state_e;

  state_e             state;
  state_e             state_nxt;
  logic               halt_ack_nxt;

  logic [PC_SIZE-1:0] pc_r;
  logic [CNT_W-1:0]   outs_cnt;
  logic [CNT_W-1:0]   stale_cnt;

  logic               req_hs;
  logic               flush_hs;
  logic [CNT_W:0]     outs_sum;
  logic [CNT_W:0]     outs_nxt;
  logic               may_raise;
  logic               req_valid_nxt;
  logic [PC_SIZE-1:0] flush_pc;

  assign ifu_req_pc = pc_r;
  assign req_hs     = ifu_req_valid & ifu_req_ready;

  // A request waiting on memory must complete before the flush is taken,
  // otherwise valid would have to drop without a handshake.
  assign pipe_flush_ack = pipe_flush_req & ~halt_req & ~(ifu_req_valid & ~ifu_req_ready);
  assign flush_hs       = pipe_flush_req & pipe_flush_ack;

  assign flush_pc = pipe_flush_add_op1 + pipe_flush_add_op2;

  assign ifu_rsp_discard = ifu_rsp_valid & (stale_cnt != '0);
  assign ifu_rsp_keep    = ifu_rsp_valid & (stale_cnt == '0);

  // Outstanding count after this cycle's accept and response. A response
  // with nothing outstanding is a protocol error; the count saturates at 0.
  always_comb begin
    outs_sum = {1'b0, outs_cnt} + {{CNT_W{1'b0}}, req_hs};
    outs_nxt = outs_sum;
    if (ifu_rsp_valid && (outs_sum != '0)) begin
      outs_nxt = outs_sum - 1'b1;
    end
  end

  // A flush handshake counts as a running, unblocked cycle so the first
  // redirected fetch is presented right after the handshake.
  always_comb begin
    may_raise = ((state == ST_RUN) | flush_hs)
              & ~halt_req
              & (~pipe_flush_req | flush_hs)
              & (outs_nxt < (CNT_W + 1)'(MAX_OUTS))
              & (~ifu_req_valid | req_hs);
    req_valid_nxt = ifu_req_valid;
    if (may_raise) begin
      req_valid_nxt = 1'b1;
    end else if (req_hs) begin
      req_valid_nxt = 1'b0;
    end
  end

  // Halt state machine: next state and registered ack value.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (halt_req) begin
          state_nxt = ST_HALTING;
        end
      end
      ST_HALTING: begin
        if (!halt_req) begin
          state_nxt = ST_RUN;
        end else if ((outs_cnt == '0) && !ifu_req_valid) begin
          state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (!halt_req) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    if (flush_hs) begin
      state_nxt = ST_RUN;
    end
    halt_ack_nxt = (state_nxt == ST_HALTED);
  end

  // Halt state register; halt_ack rises on entry to HALTED and falls on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      halt_ack <= 1'b0;
    end else begin
      state    <= state_nxt;
      halt_ack <= halt_ack_nxt;
    end
  end

  // Fetch PC and request valid. The flush redirect wins over the
  // sequential increment when both happen in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      ifu_req_valid <= 1'b0;
    end else begin
      ifu_req_valid <= req_valid_nxt;
      if (flush_hs) begin
        pc_r <= flush_pc;
      end else if (req_hs) begin
        pc_r <= pc_r + PC_SIZE'(4);
      end
    end
  end

  // Outstanding and stale counters. On a flush every in-flight request,
  // including one accepted this very cycle, becomes stale; responses
  // return in order, so the oldest stale_cnt responses are the stale ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      outs_cnt  <= '0;
      stale_cnt <= '0;
    end else begin
      outs_cnt <= outs_nxt[CNT_W-1:0];
      if (flush_hs) begin
        stale_cnt <= outs_nxt[CNT_W-1:0];
      end else if (ifu_rsp_discard) begin
        stale_cnt <= stale_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_e203_ifu_flush_rsp.sv
// Testbench for e203_ifu_flush_rsp. The driver applies one stimulus per
// cycle and advances a behavioural model that tags every accepted fetch
// with the stream it belongs to; a flush starts a new stream. Expected
// per-cycle outputs and expected response classifications are queued
// and checked by an independent monitor.

module tb_e203_ifu_flush_rsp;

  localparam int MAX_OUTS = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  localparam int MODE_RUN     = 0;
  localparam int MODE_HALTING = 1;
  localparam int MODE_HALTED  = 2;

  logic        clk;
  logic        rst;
  logic        pipe_flush_req;
  logic [31:0] pipe_flush_add_op1;
  logic [31:0] pipe_flush_add_op2;
  logic        pipe_flush_ack;
  logic        halt_req;
  logic        halt_ack;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_keep;
  logic        ifu_rsp_discard;

  typedef struct {
    bit          valid;
    logic [31:0] pc;
    bit          ack;
    bit          halt_ack;
  } cyc_t;

  cyc_t exp_q[$];
  bit   rsp_q[$];

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  bit          m_valid;
  int          m_mode;
  bit          m_halt_ack;
  int          inflight[$];
  int          cur_stream;

  e203_ifu_flush_rsp #(
    .PC_SIZE (32),
    .MAX_OUTS(MAX_OUTS),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pipe_flush_req    (pipe_flush_req),
    .pipe_flush_add_op1(pipe_flush_add_op1),
    .pipe_flush_add_op2(pipe_flush_add_op2),
    .pipe_flush_ack    (pipe_flush_ack),
    .halt_req          (halt_req),
    .halt_ack          (halt_ack),
    .ifu_req_valid     (ifu_req_valid),
    .ifu_req_ready     (ifu_req_ready),
    .ifu_req_pc        (ifu_req_pc),
    .ifu_rsp_valid     (ifu_rsp_valid),
    .ifu_rsp_keep      (ifu_rsp_keep),
    .ifu_rsp_discard   (ifu_rsp_discard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset across two rising edges and returns the model to its
  // post-reset state; nothing is queued while reset is asserted.
  task automatic resetDut();
    @(negedge clk);
    rst                = 1'b1;
    pipe_flush_req     = 1'b0;
    pipe_flush_add_op1 = '0;
    pipe_flush_add_op2 = '0;
    halt_req           = 1'b0;
    ifu_req_ready      = 1'b0;
    ifu_rsp_valid      = 1'b0;
    repeat (2) @(posedge clk);
    m_pc       = RESET_PC;
    m_valid    = 1'b0;
    m_mode     = MODE_RUN;
    m_halt_ack = 1'b0;
    inflight.delete();
    cur_stream = 0;
  endtask

  // Drives one cycle of inputs, queues what the DUT should show in that
  // cycle, then advances the model across the coming rising edge.
  task automatic applyStimulus(input bit fl, input logic [31:0] o1, input logic [31:0] o2,
                               input bit hr, input bit rdy, input bit rsp_want,
                               output bit acked);
    cyc_t e;
    bit   hs;
    bit   ack;
    bit   rsp_now;
    bit   raise;
    int   outs_now;
    int   mode_nxt;
    @(negedge clk);
    rsp_now            = rsp_want && (inflight.size() > 0);
    rst                = 1'b0;
    pipe_flush_req     = fl;
    pipe_flush_add_op1 = o1;
    pipe_flush_add_op2 = o2;
    halt_req           = hr;
    ifu_req_ready      = rdy;
    ifu_rsp_valid      = rsp_now;

    hs  = m_valid && rdy;
    ack = fl && !hr && !(m_valid && !rdy);
    e.valid    = m_valid;
    e.pc       = m_pc;
    e.ack      = ack;
    e.halt_ack = m_halt_ack;
    exp_q.push_back(e);

    outs_now = inflight.size();
    if (rsp_now) begin
      rsp_q.push_back(inflight[0] == cur_stream);
      void'(inflight.pop_front());
    end
    if (hs) inflight.push_back(cur_stream);
    if (ack) cur_stream++;

    mode_nxt = m_mode;
    if (ack || !hr) mode_nxt = MODE_RUN;
    else if (m_mode == MODE_RUN) mode_nxt = MODE_HALTING;
    else if (m_mode == MODE_HALTING && outs_now == 0 && !m_valid) mode_nxt = MODE_HALTED;

    raise = (m_mode == MODE_RUN || ack) && !hr && (!fl || ack)
            && (inflight.size() < MAX_OUTS) && (!m_valid || hs);
    if (raise) m_valid = 1'b1;
    else if (hs) m_valid = 1'b0;

    if (ack) m_pc = o1 + o2;
    else if (hs) m_pc = m_pc + 32'd4;

    m_mode     = mode_nxt;
    m_halt_ack = (mode_nxt == MODE_HALTED);
    acked      = ack;
  endtask

  // Compares one cycle of DUT outputs against the oldest queued expectation.
  task automatic checkOutput();
    cyc_t e;
    bit   k;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (ifu_req_valid !== e.valid) begin
        errors++;
        $display("[TB] FAIL req_valid: got %0b expected %0b at %0t", ifu_req_valid, e.valid, $time);
      end
      checks++;
      if (pipe_flush_ack !== e.ack) begin
        errors++;
        $display("[TB] FAIL flush_ack: got %0b expected %0b at %0t", pipe_flush_ack, e.ack, $time);
      end
      checks++;
      if (halt_ack !== e.halt_ack) begin
        errors++;
        $display("[TB] FAIL halt_ack: got %0b expected %0b at %0t", halt_ack, e.halt_ack, $time);
      end
      if (e.valid) begin
        checks++;
        if (ifu_req_pc !== e.pc) begin
          errors++;
          $display("[TB] FAIL req_pc: got %h expected %h at %0t", ifu_req_pc, e.pc, $time);
        end
      end
      if (ifu_rsp_valid) begin
        checks++;
        if (rsp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rsp_order: got response with no expectation at %0t", $time);
        end else begin
          k = rsp_q.pop_front();
          if (ifu_rsp_keep !== k || ifu_rsp_discard !== !k) begin
            errors++;
            $display("[TB] FAIL rsp_class: got keep=%0b discard=%0b expected keep=%0b discard=%0b at %0t",
                     ifu_rsp_keep, ifu_rsp_discard, k, !k, $time);
          end
        end
      end else begin
        checks++;
        if (ifu_rsp_keep !== 1'b0 || ifu_rsp_discard !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rsp_idle: got keep=%0b discard=%0b expected 0/0 at %0t",
                   ifu_rsp_keep, ifu_rsp_discard, $time);
        end
      end
    end
  endtask

  // Monitor: samples between the drive point and the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      checkOutput();
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          ak;
    bit          fl_hold;
    bit          hr;
    logic [31:0] o1;
    logic [31:0] o2;

    $display("[TB] start");
    resetDut();

    // Sequential fetch with responses one cycle after accept.
    repeat (6) applyStimulus(0, '0, '0, 0, 1, 1, ak);

    // Fill the outstanding window, then stall memory; valid must stay low.
    repeat (4) applyStimulus(0, '0, '0, 0, 1, 0, ak);
    repeat (3) applyStimulus(0, '0, '0, 0, 0, 0, ak);
    applyStimulus(0, '0, '0, 0, 0, 1, ak);
    repeat (2) applyStimulus(0, '0, '0, 0, 0, 0, ak);

    // Flush blocked by a pending request until memory accepts it.
    repeat (3) applyStimulus(1, 32'h8000_0100, 32'h20, 0, 0, 0, ak);
    applyStimulus(1, 32'h8000_0100, 32'h20, 0, 1, 1, ak);
    repeat (3) applyStimulus(0, '0, '0, 0, 1, 1, ak);

    // Flush with two in flight: both responses become stale.
    repeat (4) applyStimulus(0, '0, '0, 0, 1, 0, ak);
    applyStimulus(1, 32'h8000_0200, 32'h0, 0, 1, 0, ak);
    repeat (6) applyStimulus(0, '0, '0, 0, 1, 1, ak);

    // Flush target wraps around the address space.
    applyStimulus(1, 32'hFFFF_FFF0, 32'h20, 0, 1, 1, ak);
    repeat (4) applyStimulus(0, '0, '0, 0, 1, 1, ak);

    // Halt with fetches in flight, drain, then release.
    repeat (2) applyStimulus(0, '0, '0, 1, 1, 0, ak);
    repeat (4) applyStimulus(0, '0, '0, 1, 1, 1, ak);
    repeat (3) applyStimulus(0, '0, '0, 1, 1, 0, ak);
    repeat (5) applyStimulus(0, '0, '0, 0, 1, 1, ak);

    // Randomized traffic; a flush request is held until it is acked.
    fl_hold = 1'b0;
    hr      = 1'b0;
    o1      = '0;
    o2      = '0;
    for (int i = 0; i < 800; i++) begin
      if (!fl_hold && $urandom_range(0, 15) == 0) begin
        fl_hold = 1'b1;
        o1      = $urandom;
        o2      = $urandom;
      end
      if ($urandom_range(0, 24) == 0) hr = !hr;
      applyStimulus(fl_hold, o1, o2, hr, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) != 0, ak);
      if (ak) fl_hold = 1'b0;
    end

    // Reset in the middle of traffic drops all in-flight knowledge.
    resetDut();
    repeat (10) applyStimulus(0, '0, '0, 0, $urandom_range(0, 1) == 1, 1, ak);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
